// File: rtl/ir_pass_generator_pkg.sv
// ---------------------------------------------------------------------------
// ir_pass_generator_pkg
// Shared definitions for the IR doorway pass generator:
//   - state_t      : sequencer state encoding (IDLE, FIRST, GAP, SECOND, TAIL)
//   - DIR_ENTER / DIR_EXIT : request direction encoding
//   - phase_max()  : largest of the three phase lengths, used to size the
//                    phase timer
// ---------------------------------------------------------------------------
package ir_pass_generator_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FIRST  = 3'd1,
      GAP    = 3'd2,
      SECOND = 3'd3,
      TAIL   = 3'd4
   } state_t;

   localparam logic DIR_ENTER = 1'b0;
   localparam logic DIR_EXIT  = 1'b1;

   // Longest phase length; the timer must be able to hold that value minus one.
   function automatic int phase_max(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/ir_pass_generator_phase_timer.sv
// ---------------------------------------------------------------------------
// ir_phase_timer
// Loadable down counter with a zero flag. Each phase of the pass sequence
// loads (length - 1) on entry and ends in the cycle the counter reads zero.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset (counter -> 0)
//   load       : load load_value at the next edge (wins over counting)
//   load_value : value loaded when load is high
//   count      : current counter value
//   zero       : high while count == 0
// ---------------------------------------------------------------------------
module ir_phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] count,
   output logic         zero
);

   // Counting stops at zero so an idle timer stays parked there until the
   // sequencer loads the next phase length.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ir_pass_generator.sv
// ---------------------------------------------------------------------------
// ir_pass_generator
// Transmitter side of the two-sensor IR doorway. Each accepted request is
// turned into a non-overlapping pulse pair on ir_sensor1/ir_sensor2:
//   enter : sensor1 pulse, gap, sensor2 pulse, tail
//   exit  : sensor2 pulse, gap, sensor1 pulse, tail
// Ports:
//   clk            : system clock, rising edge
//   reset          : synchronous, active-high reset
//   req_valid      : request present
//   req_dir        : 0 = enter, 1 = exit, latched on acceptance
//   req_ready      : high only while idle
//   ir_sensor1     : emulated outer sensor (registered)
//   ir_sensor2     : emulated inner sensor (registered)
//   busy           : high from the cycle after acceptance until done
//   done           : one-cycle pulse on the last tail cycle
//   expected_count : visitor scoreboard mirror (only with IR_EXPECT_COUNT_EN)
// Optional feature macro: IR_EXPECT_COUNT_EN
// ---------------------------------------------------------------------------
module ir_pass_generator
   import ir_pass_generator_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 1,
   parameter int TAIL_CYCLES  = 3,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_dir,
   output logic             req_ready,
   output logic             ir_sensor1,
   output logic             ir_sensor2,
   output logic             busy,
`ifdef IR_EXPECT_COUNT_EN
   output logic             done,
   output logic [CNT_W-1:0] expected_count
`else
   output logic             done
`endif
);

   localparam int TMR_W = $clog2(phase_max(PULSE_CYCLES, GAP_CYCLES, TAIL_CYCLES) + 1);

   localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] TAIL_LOAD  = TMR_W'(TAIL_CYCLES - 1);
   localparam logic             TAIL_IS_ONE = (TAIL_CYCLES == 1);

   state_t             state;
   logic               dir_latched;
   logic               timer_load;
   logic [TMR_W-1:0]   timer_value;
   logic [TMR_W-1:0]   timer_count;
   logic               timer_zero;

   assign req_ready = (state == IDLE);

   // The timer is reloaded at exactly the edges where the sequencer moves
   // into a new timed phase, so the counter always describes the phase the
   // state register is about to enter.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               timer_load  = 1'b1;
               timer_value = PULSE_LOAD;
            end
         end
         FIRST: begin
            if (timer_zero) begin
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         GAP: begin
            if (timer_zero) begin
               timer_load  = 1'b1;
               timer_value = PULSE_LOAD;
            end
         end
         SECOND: begin
            if (timer_zero) begin
               timer_load  = 1'b1;
               timer_value = TAIL_LOAD;
            end
         end
         default: begin
            timer_load  = 1'b0;
            timer_value = '0;
         end
      endcase
   end

   ir_phase_timer #(
      .W (TMR_W)
   ) u_phase_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .count      (timer_count),
      .zero       (timer_zero)
   );

   // Sequencer with registered outputs. Sensor levels are set on the edge
   // that enters each phase so they line up with the state register, which
   // guarantees the two sensors are never high together. done is raised one
   // edge ahead of the last tail cycle (timer at 1), or directly on entry to
   // the tail when the tail is a single cycle long.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         dir_latched <= DIR_ENTER;
         ir_sensor1  <= 1'b0;
         ir_sensor2  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state       <= FIRST;
                  dir_latched <= req_dir;
                  busy        <= 1'b1;
                  ir_sensor1  <= (req_dir == DIR_ENTER);
                  ir_sensor2  <= (req_dir == DIR_EXIT);
               end
            end
            FIRST: begin
               if (timer_zero) begin
                  state      <= GAP;
                  ir_sensor1 <= 1'b0;
                  ir_sensor2 <= 1'b0;
               end
            end
            GAP: begin
               if (timer_zero) begin
                  state      <= SECOND;
                  ir_sensor1 <= (dir_latched == DIR_EXIT);
                  ir_sensor2 <= (dir_latched == DIR_ENTER);
               end
            end
            SECOND: begin
               if (timer_zero) begin
                  state      <= TAIL;
                  ir_sensor1 <= 1'b0;
                  ir_sensor2 <= 1'b0;
                  done       <= TAIL_IS_ONE;
               end
            end
            TAIL: begin
               if (timer_zero) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  done <= (timer_count == TMR_W'(1));
               end
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               done       <= 1'b0;
               ir_sensor1 <= 1'b0;
               ir_sensor2 <= 1'b0;
            end
         endcase
      end
   end

`ifdef IR_EXPECT_COUNT_EN
   // Scoreboard mirror of the visitor counter: it moves on the edge that
   // closes the done cycle, using the direction of the sequence that just
   // finished, and saturates at both ends instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         expected_count <= '0;
      end else if (done) begin
         if (dir_latched == DIR_ENTER) begin
            if (expected_count != '1) begin
               expected_count <= expected_count + CNT_W'(1);
            end
         end else begin
            if (expected_count != '0) begin
               expected_count <= expected_count - CNT_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ir_pass_generator.sv
// ---------------------------------------------------------------------------
// tb_ir_pass_generator
// Self-checking bench for ir_pass_generator with default parameters.
// A timeline model (offset of the current cycle from the last acceptance)
// predicts every output each cycle; directed tests add literal expectations.
// Optional feature macro honoured: IR_EXPECT_COUNT_EN
// ---------------------------------------------------------------------------
module tb_ir_pass_generator;

   localparam int P   = 4;
   localparam int G   = 1;
   localparam int T   = 3;
   localparam int CW  = 8;
   localparam int SEQ = 2 * P + G + T;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_dir = 1'b0;
   logic          req_ready;
   logic          ir_sensor1;
   logic          ir_sensor2;
   logic          busy;
   logic          done;
`ifdef IR_EXPECT_COUNT_EN
   logic [CW-1:0] expected_count;
`endif

   int vectors     = 0;
   int miscompares = 0;
   bit checking    = 1'b0;
   int cyc         = 0;

   bit   m_active = 1'b0;
   int   m_k      = 0;
   logic m_dir    = 1'b0;
   int   m_count  = 0;

   bit e_first;
   bit e_second;
   bit e_s1;
   bit e_s2;

   ir_pass_generator #(
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G),
      .TAIL_CYCLES  (T),
      .CNT_W        (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_dir        (req_dir),
      .req_ready      (req_ready),
      .ir_sensor1     (ir_sensor1),
      .ir_sensor2     (ir_sensor2),
      .busy           (busy),
`ifdef IR_EXPECT_COUNT_EN
      .done           (done),
      .expected_count (expected_count)
`else
      .done           (done)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle counter used to time acceptances.
   always @(posedge clk) cyc <= cyc + 1;

   // Timeline model: m_k is the number of edges since acceptance, so cycle k
   // of a sequence is observed with m_k == k. The request is retired and the
   // visitor mirror updated on the edge that closes cycle SEQ.
   always @(posedge clk) begin
      if (reset) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_count  <= 0;
      end else if (m_active) begin
         if (m_k == SEQ) begin
            m_active <= 1'b0;
            if (m_dir == 1'b0)
               m_count <= (m_count == (2 ** CW) - 1) ? m_count : m_count + 1;
            else
               m_count <= (m_count == 0) ? 0 : m_count - 1;
         end
         m_k <= m_k + 1;
      end else if (req_valid) begin
         m_active <= 1'b1;
         m_k      <= 1;
         m_dir    <= req_dir;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Every-cycle comparison against the timeline model.
   always @(negedge clk) begin
      if (checking) begin
         e_first  = m_active && (m_k >= 1) && (m_k <= P);
         e_second = m_active && (m_k >= P + G + 1) && (m_k <= 2 * P + G);
         e_s1     = m_dir ? e_second : e_first;
         e_s2     = m_dir ? e_first : e_second;
         checkOutput("model_req_ready", req_ready, !m_active);
         checkOutput("model_busy", busy, m_active);
         checkOutput("model_sensor1", ir_sensor1, e_s1);
         checkOutput("model_sensor2", ir_sensor2, e_s2);
         checkOutput("model_done", done, m_active && (m_k == SEQ));
         checkOutput("sensors_exclusive", ir_sensor1 & ir_sensor2, 1'b0);
`ifdef IR_EXPECT_COUNT_EN
         checkOutput("model_count", expected_count, m_count);
`endif
      end
   end

   // Waits (bounded) for req_ready, then presents a one-cycle request.
   // Called at a negedge; returns at the negedge of cycle 1 of the sequence.
   task automatic applyStimulus(input logic dir);
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL ready_timeout: req_ready got 0 expected 1");
      end
      req_valid = 1'b1;
      req_dir   = dir;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Literal cycle-by-cycle expectations for one default-parameter sequence.
   task automatic pinSequence(input logic dir, input int count_after);
      logic [13:0] pin_first;
      logic [13:0] pin_second;
      logic [13:0] pin_done;
      logic [13:0] pin_ready;
      logic [13:0] pin_s1;
      logic [13:0] pin_s2;
      pin_first  = 14'b00_0000_0001_1110;
      pin_second = 14'b00_0011_1100_0000;
      pin_done   = 14'b01_0000_0000_0000;
      pin_ready  = 14'b10_0000_0000_0000;
      pin_s1     = dir ? pin_second : pin_first;
      pin_s2     = dir ? pin_first : pin_second;
      applyStimulus(dir);
      for (int n = 1; n <= 13; n++) begin
         if (n > 1) @(negedge clk);
         checkOutput("pin_sensor1", ir_sensor1, pin_s1[n]);
         checkOutput("pin_sensor2", ir_sensor2, pin_s2[n]);
         checkOutput("pin_done", done, pin_done[n]);
         checkOutput("pin_ready", req_ready, pin_ready[n]);
      end
`ifdef IR_EXPECT_COUNT_EN
      checkOutput("pin_count", expected_count, count_after);
`else
      if (count_after < 0) $display("[TB] unexpected negative count");
`endif
   endtask

   initial begin
      int acc;
      int acc_t [4];

      // Reset held for three edges, then released.
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      checking = 1'b1;
      checkOutput("reset_sensor1", ir_sensor1, 1'b0);
      checkOutput("reset_sensor2", ir_sensor2, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_ready", req_ready, 1'b1);
`ifdef IR_EXPECT_COUNT_EN
      checkOutput("reset_count", expected_count, 0);
`endif

      $display("[TB] enter sequence");
      pinSequence(1'b0, 1);
      $display("[TB] exit sequence");
      pinSequence(1'b1, 0);
      $display("[TB] exit at zero (saturation)");
      pinSequence(1'b1, 0);

      $display("[TB] four back-to-back enters with req_valid held");
      acc       = 0;
      req_valid = 1'b1;
      req_dir   = 1'b0;
      for (int n = 0; n < 80 && acc < 4; n++) begin
         if (req_ready) begin
            acc_t[acc] = cyc;
            acc++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("held_accept_count", acc, 4);
      for (int i = 1; i < 4; i++)
         checkOutput("held_accept_spacing", acc_t[i] - acc_t[i-1], 13);
      for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
      checkOutput("held_ready_after", req_ready, 1'b1);
`ifdef IR_EXPECT_COUNT_EN
      checkOutput("held_count", expected_count, 4);
`endif

      $display("[TB] reset during an enter sequence");
      applyStimulus(1'b0);
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset_sensor1", ir_sensor1, 1'b0);
      checkOutput("midreset_sensor2", ir_sensor2, 1'b0);
      checkOutput("midreset_busy", busy, 1'b0);
      checkOutput("midreset_done", done, 1'b0);
`ifdef IR_EXPECT_COUNT_EN
      checkOutput("midreset_count", expected_count, 0);
`endif
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midreset_ready", req_ready, 1'b1);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checkOutput("midreset_no_done", done, 1'b0);
      end

      $display("[TB] req_dir toggled while busy");
      applyStimulus(1'b0);
      req_valid = 1'b1;
      req_dir   = 1'b1;
      for (int n = 2; n <= 13; n++) begin
         @(negedge clk);
         if (n == 7) req_dir = 1'b0;
         if (n == 8) req_dir = 1'b1;
         if (n >= 6 && n <= 9) begin
            checkOutput("toggle_sensor2", ir_sensor2, 1'b1);
            checkOutput("toggle_sensor1", ir_sensor1, 1'b0);
         end
         if (n == 12) req_valid = 1'b0;
      end
      checkOutput("toggle_ready", req_ready, 1'b1);
`ifdef IR_EXPECT_COUNT_EN
      checkOutput("toggle_count", expected_count, 1);
`endif

      repeat (3) @(negedge clk);
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
